// File: rtl/mmul_tile_controller.sv
// Tile sequencer for an output-stationary N x N systolic array: clears the
// accumulators, streams K operand beats, flushes the skew, then drains N result rows.
module mmul_tile_controller #(
  parameter int unsigned N            = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned KW           = 8,
  parameter int unsigned CW           = 32,
  localparam int unsigned RSW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [KW-1:0]                  i_k_len,
  input  logic [2*N*DATA_WIDTH-1:0]      i_in_tdata,
  input  logic                           i_in_tvalid,
  output logic                           o_in_tready,
  output logic [N*DATA_WIDTH-1:0]        o_arr_a,
  output logic [N*DATA_WIDTH-1:0]        o_arr_b,
  output logic                           o_arr_en,
  output logic                           o_arr_clear,
  output logic [RSW-1:0]                 o_arr_row_sel,
  input  logic [N*RESULT_WIDTH-1:0]      i_arr_result,
  output logic [N*RESULT_WIDTH-1:0]      o_out_tdata,
  output logic                           o_out_tvalid,
  input  logic                           i_out_tready,
  output logic                           o_out_tlast,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [CW-1:0]                  o_perf_cycles
);

  localparam int unsigned SliceW    = N * DATA_WIDTH;
  localparam int unsigned FlushLen  = 2 * N - 1;
  localparam int unsigned FW        = $clog2(2 * N);
  localparam logic [FW-1:0]  FlushLast = FW'(FlushLen - 1);
  localparam logic [RSW-1:0] RowLast   = RSW'(N - 1);
  localparam logic [CW-1:0]  PerfMax   = '1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StFlush,
    StDrain,
    StDone
  } state_e;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [KW-1:0]  r_k_len;
  logic [KW-1:0]  r_beat;
  logic [FW-1:0]  r_flush;
  logic [RSW-1:0] r_row;
  logic [CW-1:0]  r_perf;

  logic          w_start_ok;
  logic          w_in_hs;
  logic          w_out_hs;
  logic [KW-1:0] w_beat_nxt;
  logic          w_last_beat;
  logic          w_last_flush;
  logic          w_last_row;
  logic          w_count;

  assign w_start_ok   = (r_state == StIdle) && i_start && (i_k_len != '0);
  assign w_in_hs      = (r_state == StFeed) && i_in_tvalid;
  assign w_out_hs     = (r_state == StDrain) && i_out_tready;
  assign w_beat_nxt   = r_beat + KW'(1);
  assign w_last_beat  = (w_beat_nxt == r_k_len);
  assign w_last_flush = (r_flush == FlushLast);
  assign w_last_row   = (r_row == RowLast);
  // DONE is deliberately excluded so perf_cycles is final while done pulses.
  assign w_count      = (r_state == StClear) || (r_state == StFeed) ||
                        (r_state == StFlush) || (r_state == StDrain);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start_ok) w_state_nxt = StClear;
      StClear: w_state_nxt = StFeed;
      StFeed:  if (w_in_hs && w_last_beat) w_state_nxt = StFlush;
      StFlush: if (w_last_flush) w_state_nxt = StDrain;
      StDrain: if (w_out_hs && w_last_row) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_in_tready  = 1'b0;
    o_arr_en     = 1'b0;
    o_arr_clear  = 1'b0;
    o_arr_a      = '0;
    o_arr_b      = '0;
    o_out_tvalid = 1'b0;
    o_out_tdata  = '0;
    o_out_tlast  = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      StClear: o_arr_clear = 1'b1;
      StFeed: begin
        o_in_tready = 1'b1;
        o_arr_en    = i_in_tvalid;
        // Operands go straight through; a bubble presents zeros and freezes the array.
        if (i_in_tvalid) begin
          o_arr_a = i_in_tdata[SliceW-1:0];
          o_arr_b = i_in_tdata[2*SliceW-1:SliceW];
        end
      end
      StFlush: o_arr_en = 1'b1;
      StDrain: begin
        o_out_tvalid = 1'b1;
        o_out_tdata  = i_arr_result;
        o_out_tlast  = w_last_row;
      end
      StDone:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_busy        = (r_state != StIdle);
  assign o_arr_row_sel = r_row;
  assign o_perf_cycles = r_perf;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_k_len <= '0;
      r_beat  <= '0;
      r_flush <= '0;
      r_row   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start_ok) begin
            r_k_len <= i_k_len;
            r_beat  <= '0;
            r_flush <= '0;
            r_row   <= '0;
          end
        end
        StFeed:  if (w_in_hs) r_beat <= w_beat_nxt;
        StFlush: r_flush <= w_last_flush ? '0 : r_flush + FW'(1);
        StDrain: begin
          if (w_out_hs) r_row <= w_last_row ? '0 : r_row + RSW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf <= '0;
    end else if (w_start_ok) begin
      r_perf <= '0;
    end else if (w_count && (r_perf != PerfMax)) begin
      r_perf <= r_perf + CW'(1);
    end
  end

  // Structural invariants of the sequencer.
  a_no_overlap : assert property (@(posedge i_clk) disable iff (i_reset)
    !(o_in_tready && o_out_tvalid));
  a_clear_alone : assert property (@(posedge i_clk) disable iff (i_reset)
    o_arr_clear |-> !o_arr_en);
  a_done_busy : assert property (@(posedge i_clk) disable iff (i_reset)
    o_done |-> o_busy);
  a_beat_bound : assert property (@(posedge i_clk) disable iff (i_reset)
    (r_state == StFeed) |-> (r_beat < r_k_len));

endmodule
